// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
// Command-driven sequencer for a single INT8 MAC unit. One command computes
// the dot product of two vectors held in operand SRAMs. Operands are fetched
// through two 1-cycle-latency read ports and streamed into the MAC. The MAC
// pipeline is then drained and the 32-bit sum is captured. The raw sum and a
// rounded, shifted, INT8-saturated copy are returned on a valid/ready channel.
//
// Timing for N > 0 (cycle 0 = command handshake):
//   cycles 1..N     FETCH, rd_en=1, addresses base+0 .. base+N-1
//   cycles 2..N+1   mac_en=1, operands forwarded from rd_data_*
//   cycles N+2,N+3  mac_en=1, zero operands (pipeline drain)
//   cycle  N+4      CAPTURE mac_result
//   cycle  N+5..    DONE, res_valid=1 until res_ready
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_base_a/b, cmd_len          operand base addresses, element count N
//   cmd_shift                      requantization right-shift S
//   rd_en, rd_addr_a/b, rd_data_a/b operand SRAM read ports (1-cycle latency)
//   mac_a, mac_b, mac_en, mac_acc  MAC drive (mac_acc=0 means load)
//   mac_result                     MAC accumulator register
//   res_valid/res_ready            result handshake
//   res_acc, res_q8, res_sat       raw sum, requantized INT8, clip flag
//   busy                           sequencer not idle
module mac_seq_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int LEN_WIDTH   = 10,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_WIDTH-1:0]  cmd_base_a,
  input  logic [ADDR_WIDTH-1:0]  cmd_base_b,
  input  logic [LEN_WIDTH-1:0]   cmd_len,
  input  logic [SHIFT_WIDTH-1:0] cmd_shift,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  rd_addr_a,
  output logic [ADDR_WIDTH-1:0]  rd_addr_b,
  input  logic [DATA_WIDTH-1:0]  rd_data_a,
  input  logic [DATA_WIDTH-1:0]  rd_data_b,
  output logic [DATA_WIDTH-1:0]  mac_a,
  output logic [DATA_WIDTH-1:0]  mac_b,
  output logic                   mac_en,
  output logic                   mac_acc,
  input  logic [ACC_WIDTH-1:0]   mac_result,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ACC_WIDTH-1:0]   res_acc,
  output logic [DATA_WIDTH-1:0]  res_q8,
  output logic                   res_sat,
  output logic                   busy
);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, CAPTURE, DONE} state_t;

  // Cycle counter must reach N+3 with N up to 2^LEN_WIDTH-1.
  localparam int CYC_W  = LEN_WIDTH + 2;
  localparam int QMAX_I = (1 << (DATA_WIDTH - 1)) - 1;
  localparam logic signed [ACC_WIDTH:0] Q_MAX = (ACC_WIDTH + 1)'(QMAX_I);
  localparam logic signed [ACC_WIDTH:0] Q_MIN = (ACC_WIDTH + 1)'(-QMAX_I - 1);

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  base_a_q;
  logic [ADDR_WIDTH-1:0]  base_b_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic [CYC_W-1:0]       cyc;       // current cycle number since handshake
  logic [CYC_W-1:0]       len_ext;
  logic                   mac_pass;  // forward SRAM data onto the MAC operands

  assign len_ext   = CYC_W'(len_q);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // SRAM data arrives one cycle after the read strobe, so operands are
  // forwarded combinationally in the enable cycle rather than re-registered.
  assign mac_a = mac_pass ? rd_data_a : '0;
  assign mac_b = mac_pass ? rd_data_b : '0;

  // Requantization of the MAC result, evaluated for the CAPTURE cycle.
  logic signed [ACC_WIDTH:0] acc_ext;
  logic signed [ACC_WIDTH:0] rnd;
  logic signed [ACC_WIDTH:0] shifted;
  logic [DATA_WIDTH-1:0]     q8_next;
  logic                      sat_next;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    acc_ext  = {mac_result[ACC_WIDTH-1], mac_result};
    rnd      = '0;
    q8_next  = '0;
    sat_next = 1'b0;
    if (shift_q != '0) begin
      rnd = (ACC_WIDTH + 1)'(1) << (shift_q - 1'b1);
    end
    // Round half up, then arithmetic shift; S=0 passes the sum through.
    shifted = (acc_ext + rnd) >>> shift_q;
    if (shifted > Q_MAX) begin
      q8_next  = Q_MAX[DATA_WIDTH-1:0];
      sat_next = 1'b1;
    end else if (shifted < Q_MIN) begin
      q8_next  = Q_MIN[DATA_WIDTH-1:0];
      sat_next = 1'b1;
    end else begin
      q8_next  = shifted[DATA_WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base_a_q  <= '0;
      base_b_q  <= '0;
      len_q     <= '0;
      shift_q   <= '0;
      cyc       <= '0;
      mac_pass  <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      mac_en    <= 1'b0;
      mac_acc   <= 1'b0;
      res_valid <= 1'b0;
      res_acc   <= '0;
      res_q8    <= '0;
      res_sat   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            base_a_q <= cmd_base_a;
            base_b_q <= cmd_base_b;
            len_q    <= cmd_len;
            shift_q  <= cmd_shift;
            if (cmd_len == '0) begin
              // Empty vector: result is zero, MAC and SRAMs stay untouched.
              state     <= DONE;
              res_valid <= 1'b1;
              res_acc   <= '0;
              res_q8    <= '0;
              res_sat   <= 1'b0;
            end else begin
              state     <= FETCH;
              rd_en     <= 1'b1;
              rd_addr_a <= cmd_base_a;
              rd_addr_b <= cmd_base_b;
              cyc       <= CYC_W'(1);
            end
          end
        end

        FETCH: begin
          // Outputs computed here are for cycle cyc+1.
          cyc      <= cyc + 1'b1;
          mac_en   <= 1'b1;
          mac_pass <= 1'b1;
          // The first two enables load: flush the stale product, then load
          // product 0. Later enables accumulate.
          mac_acc  <= (cyc >= CYC_W'(3));
          if (cyc == len_ext) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            // Address offset for the next cycle equals the current cycle
            // number; the sum wraps modulo 2^ADDR_WIDTH.
            rd_addr_a <= base_a_q + ADDR_WIDTH'(cyc);
            rd_addr_b <= base_b_q + ADDR_WIDTH'(cyc);
          end
        end

        DRAIN: begin
          // Covers cycles N+1..N+3; zero operands push the last products
          // through the MAC pipeline.
          cyc      <= cyc + 1'b1;
          mac_pass <= 1'b0;
          if (cyc == len_ext + CYC_W'(3)) begin
            state   <= CAPTURE;
            mac_en  <= 1'b0;
            mac_acc <= 1'b0;
          end else begin
            mac_en  <= 1'b1;
            mac_acc <= (cyc >= CYC_W'(3));
          end
        end

        CAPTURE: begin
          res_acc   <= mac_result;
          res_q8    <= q8_next;
          res_sat   <= sat_next;
          res_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Command-driven sequencer for one INT8 MAC unit. It computes a dot product of two vectors held in operand SRAMs. It fetches the operands through two 1-cycle-latency read ports, drives the MAC enable, accumulate and operand pins (including pipeline drain), then captures the 32-bit sum. It returns the raw sum plus a rounded, shifted, INT8-saturated copy over a valid/ready result channel.

Parameters:
DATA_WIDTH, 8, operand width (signed)
ACC_WIDTH, 32, MAC accumulator/result width (signed)
ADDR_WIDTH, 10, operand SRAM address width
LEN_WIDTH, 10, vector length field width (0..2^LEN_WIDTH-1)
SHIFT_WIDTH, 5, requantization shift field width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both high
cmd_base_a  in  ADDR_WIDTH  activation vector base address
cmd_base_b  in  ADDR_WIDTH  weight vector base address
cmd_len  in  LEN_WIDTH  element count N
cmd_shift  in  SHIFT_WIDTH  requant right-shift S
rd_en  out  1  read strobe, both SRAMs
rd_addr_a  out  ADDR_WIDTH  activation read address
rd_addr_b  out  ADDR_WIDTH  weight read address
rd_data_a  in  DATA_WIDTH  activation data, valid cycle after rd_en
rd_data_b  in  DATA_WIDTH  weight data, valid cycle after rd_en
mac_a  out  DATA_WIDTH  MAC activation operand
mac_b  out  DATA_WIDTH  MAC weight operand
mac_en  out  1  MAC enable
mac_acc  out  1  MAC accumulate (0 = load)
mac_result  in  ACC_WIDTH  MAC result register
res_valid  out  1  result available
res_ready  in  1  result consumed when both high
res_acc  out  ACC_WIDTH  raw dot product
res_q8  out  DATA_WIDTH  requantized, saturated result
res_sat  out  1  res_q8 was clipped
busy  out  1  state != IDLE

Behaviour:
- Reset (any cycle, including mid-operation): state IDLE. cmd_ready=1. rd_en=0, rd_addr_*=0. mac_en=0, mac_acc=0, mac_a=mac_b=0. res_valid=0, res_acc=0, res_q8=0, res_sat=0. busy=0. In-flight command discarded.
- States: IDLE, FETCH, DRAIN, CAPTURE, DONE.
- IDLE: cmd_ready=1, the only state with cmd_ready=1. On handshake, latch base_a, base_b, N, S. If N=0, go to DONE with res_acc=0, res_q8=0, res_sat=0 and no rd_en or mac_en activity. Otherwise go to FETCH with cnt=0.
- FETCH (N cycles): rd_en=1, rd_addr_a=base_a+cnt, rd_addr_b=base_b+cnt. Addresses wrap modulo 2^ADDR_WIDTH. cnt increments each cycle. After cnt=N-1, go to DRAIN.
- MAC drive timing (cycle 0 = command handshake):
  - Issue cycles 1..N: FETCH, rd_en=1.
  - Enable cycles 2..N+1: mac_en=1, mac_a/mac_b = rd_data_a/rd_data_b from that cycle.
  - Drain cycles N+2, N+3: mac_en=1, mac_a=mac_b=0.
  - mac_acc=0 on the first two mac_en cycles and 1 on all later ones. This flushes the stale product register and loads product 0 on the second enable.
  - mac_en=0 in all other cycles.
- DRAIN: covers cycles N+1..N+3, then CAPTURE.
- CAPTURE (cycle N+4): register res_acc <= mac_result and compute res_q8/res_sat. Go to DONE.
- DONE: res_valid=1 from cycle N+5. Outputs held stable until res_valid&res_ready, then go to IDLE. cmd_ready=1 on the following cycle (no same-cycle command accept).
- Requant arithmetic, in ACC_WIDTH+1 bits signed:
  - S=0: v=res_acc.
  - Else: v=(res_acc + 2^(S-1)) >>> S (arithmetic, round half up).
  - res_q8 = clamp(v, -2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1).
  - res_sat=1 if clamped.
- Accumulator wraps modulo 2^ACC_WIDTH; no overflow detection.
- cmd_valid while busy: ignored and not latched; cmd_ready=0.
- res_ready with res_valid=0: no effect.
- Latency for N>0: result valid N+5 cycles after command handshake. Throughput: one command per N+6 cycles minimum.

Test Plan:
- Reset then N=4, a=[1,2,3,4] at base 0x010, b=[5,6,7,8] at 0x200, S=0 -> rd_addr_a 0x010..0x013, mac_en high cycles 2..7, res_valid at cycle 9, res_acc=70, res_q8=70, res_sat=0.
- N=1, a=-128, b=-128, S=7 -> res_acc=16384, v=128, res_q8=127, res_sat=1. Repeat with S=8 -> res_q8=64, res_sat=0.
- N=0 -> no rd_en or mac_en pulses, res_valid next cycle, res_acc=0. Back-to-back with N=2 afterwards -> second result correct (stale MAC state flushed).
- base_a=0x3FE, N=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001; sum correct.
- res_ready held low 10 cycles, cmd_valid asserted throughout -> res_* stable, cmd_ready=0. res_ready pulse -> IDLE, new command accepted next cycle.
- Assert rst during FETCH of N=16 -> all outputs at reset values next cycle. New N=2 command (3*3 + -1*2) -> res_acc=7.
